// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package riscv_mem_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_BUSY  = 2'd1,
        I_BUSY  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Counts BUSY cycles of one memory access; expire pulses on the TIMEOUT-th cycle without ready.
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic ready,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (busy && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = busy & ~ready & (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises data (first) and fetch accesses onto one variable-latency memory,
// stalling the pipeline until all pending accesses finish, then releases for one cycle.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    input  logic              dm_ce,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_t        state_q, state_d;
    logic              start, busy, expire, done;
    logic [DATA_W-1:0] rdata_in;
    logic              req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_inst_q, dm_rdata_q;
    logic              if_served_q, dm_served_q, err_q;

    assign busy     = (state_q == D_BUSY) || (state_q == I_BUSY);
    assign done     = busy & (mem_ready | expire);
    assign rdata_in = mem_ready ? mem_rdata : '0;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .ready  (mem_ready),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_ce) begin
                    state_d = D_BUSY;
                    start   = 1'b1;
                end else if (if_ce) begin
                    state_d = I_BUSY;
                    start   = 1'b1;
                end
            end
            D_BUSY: begin
                if (done) begin
                    if (if_ce) begin
                        state_d = I_BUSY;
                        start   = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            I_BUSY:  if (done) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus is registered from the next state so a D->I handover keeps mem_req high.
    always_comb begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == D_BUSY) begin
            req_d   = 1'b1;
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
        end else if (state_d == I_BUSY) begin
            req_d   = 1'b1;
            addr_d  = if_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_inst_q   <= '0;
            dm_rdata_q  <= '0;
            if_served_q <= 1'b0;
            dm_served_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= req_d;
            mem_we_q    <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            err_q       <= err_q | expire;
            if ((state_q == D_BUSY) && done) begin
                dm_rdata_q  <= mem_we_q ? '0 : rdata_in;
                dm_served_q <= ~mem_we_q;
            end
            if ((state_q == I_BUSY) && done) begin
                if_inst_q   <= rdata_in;
                if_served_q <= 1'b1;
            end
            if (state_q == RELEASE) begin
                if_served_q <= 1'b0;
                dm_served_q <= 1'b0;
            end
        end
    end

    // A request withdrawn mid-round (flush) discards its result.
    assign if_valid  = (state_q == RELEASE) & if_served_q & if_ce;
    assign dm_valid  = (state_q == RELEASE) & dm_served_q & dm_ce;
    assign stall_req = rst & (state_q != RELEASE) & (if_ce | dm_ce);

    assign if_inst   = if_inst_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule
